// File: rtl/field_entry_pkg.sv
// Shared definitions for the multi-target field entry controller.
// State encoding, size limits and step-count lookup.
package field_entry_pkg;

  localparam int MAX_TARGETS = 8;
  localparam int MAX_FIELDS  = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EDIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    EDIT   = ST_EDIT,
    COMMIT = ST_COMMIT
  } state_t;

  // Field count of one target from the packed 3-bit table.
  function automatic logic [2:0] steps_of(
    input logic [3*MAX_TARGETS-1:0] steps,
    input logic [2:0]               tgt
  );
    int idx;
    idx = int'(tgt) * 3;
    return steps[idx +: 3];
  endfunction

endpackage

// File: rtl/field_entry_ctrl_timeout.sv
// Inactivity timer for field entry.
// Counts ticks since the last clear; expire flags the final tick.
module entry_timeout #(
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam int W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam int LAST_I = (TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0;
  localparam logic [W-1:0] LAST = W'(LAST_I);

  logic [W-1:0] count;

  // Tick counter, cleared by activity or outside editing.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  if (TIMEOUT_TICKS > 0) begin : g_on
    assign expire = tick && (count == LAST);
  end else begin : g_off
    assign expire = 1'b0;
  end

endmodule

// File: rtl/field_entry_ctrl.sv
// Multi-target, multi-field value entry sequencer.
// Preloads, captures switch values per field, commits or aborts.
module field_entry_ctrl
  import field_entry_pkg::*;
#(
  parameter int NUM_TARGETS   = 3,
  parameter int NUM_FIELDS    = 3,
  parameter int FIELD_W       = 8,
  parameter logic [3*NUM_TARGETS-1:0] TARGET_STEPS = {3'd2, 3'd3, 3'd2},
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_TARGETS-1:0]        req,
  input  logic                          btn_next,
  input  logic                          btn_back,
  input  logic                          btn_cancel,
  input  logic                          tick,
  input  logic [FIELD_W-1:0]            sw_in,
  input  logic [NUM_FIELDS*FIELD_W-1:0] preset_in,
  output logic                          busy,
  output logic [2:0]                    target,
  output logic [2:0]                    step,
  output logic [NUM_FIELDS*FIELD_W-1:0] buf_out,
  output logic [NUM_TARGETS-1:0]        commit,
  output logic                          aborted
);

  localparam logic [3*MAX_TARGETS-1:0] STEPS_ALL =
    (3*MAX_TARGETS)'(TARGET_STEPS);

  state_t     state;
  logic [2:0] req_idx;
  logic       req_any;
  logic [2:0] last_step;
  logic       any_btn;
  logic       expire;
  logic       tmo;
  logic       tmr_clr;

  // Lowest set request wins.
  always_comb begin
    req_idx = 3'd0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (req[i]) req_idx = 3'(i);
    end
  end

  assign req_any   = |req;
  assign last_step = steps_of(STEPS_ALL, target) - 3'd1;
  assign any_btn   = btn_next | btn_back | btn_cancel;
  assign tmo       = (state == EDIT) && expire && !any_btn;
  assign tmr_clr   = (state != EDIT) | any_btn;

  entry_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .tick  (tick),
    .expire(expire)
  );

  // Entry FSM with registered outputs and live field capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      target  <= 3'd0;
      step    <= 3'd0;
      buf_out <= '0;
      commit  <= '0;
      aborted <= 1'b0;
    end else begin
      commit  <= '0;
      aborted <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_any) begin
            target  <= req_idx;
            buf_out <= preset_in;
            step    <= 3'd0;
            busy    <= 1'b1;
            state   <= EDIT;
          end
        end
        EDIT: begin
          for (int i = 0; i < NUM_FIELDS; i++) begin
            if ((3'(i) == step) && (3'(i) <= last_step)) begin
              buf_out[i*FIELD_W +: FIELD_W] <= sw_in;
            end
          end
          if (btn_cancel || tmo) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (btn_next) begin
            if (step >= last_step) begin
              commit <= NUM_TARGETS'(1) << target;
              state  <= COMMIT;
            end else begin
              step <= step + 3'd1;
            end
          end else if (btn_back) begin
            if (step != 3'd0) step <= step - 3'd1;
          end
        end
        COMMIT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_field_entry_ctrl.sv
// Scoreboard bench for field_entry_ctrl.
// Directed sequences; monitor checks commit/abort events.
module tb_field_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic        btn_next, btn_back, btn_cancel, tick;
  logic [7:0]  sw_in;
  logic [23:0] preset_in;
  logic        busy;
  logic [2:0]  target, step;
  logic [23:0] buf_out;
  logic [2:0]  commit;
  logic        aborted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ab;
    logic [2:0]  cm;
    logic [23:0] bf;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  field_entry_ctrl #(
    .NUM_TARGETS(3), .NUM_FIELDS(3), .FIELD_W(8),
    .TARGET_STEPS({3'd2, 3'd3, 3'd2}),
    .TIMEOUT_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .btn_next(btn_next), .btn_back(btn_back),
    .btn_cancel(btn_cancel), .tick(tick),
    .sw_in(sw_in), .preset_in(preset_in),
    .busy(busy), .target(target), .step(step),
    .buf_out(buf_out), .commit(commit), .aborted(aborted)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_commit(input logic [2:0] cm, input logic [23:0] bf);
    exp_t e;
    e.ab = 1'b0; e.cm = cm; e.bf = bf;
    q.push_back(e);
  endtask

  task automatic push_abort();
    exp_t e;
    e.ab = 1'b1; e.cm = 3'b000; e.bf = '0;
    q.push_back(e);
  endtask

  // Monitor: every output event must match the queue head.
  always @(negedge clk) begin
    if (commit != 3'b000 || aborted) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: commit=%b aborted=%b",
                 commit, aborted);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ev_commit", 32'(commit), 32'(e.cm));
        chk("ev_aborted", 32'(aborted), 32'(e.ab));
        if (!e.ab) chk("ev_buf", 32'(buf_out), 32'(e.bf));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic press(input logic n, input logic b, input logic c,
                       input logic [7:0] sw);
    sw_in = sw;
    btn_next = n; btn_back = b; btn_cancel = c;
    cyc();
    btn_next = 1'b0; btn_back = 1'b0; btn_cancel = 1'b0;
  endtask

  task automatic pulse_req(input logic [2:0] r);
    req = r;
    cyc();
    req = 3'b000;
  endtask

  task automatic pulse_tick(input logic n);
    tick = 1'b1;
    btn_next = n;
    cyc();
    tick = 1'b0;
    btn_next = 1'b0;
    cyc();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_target"}, 32'(target), 0);
    chk({tag, "_step"}, 32'(step), 0);
    chk({tag, "_buf"}, 32'(buf_out), 0);
    chk({tag, "_commit"}, 32'(commit), 0);
    chk({tag, "_aborted"}, 32'(aborted), 0);
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; tick = 1'b0;
    btn_next = 1'b0; btn_back = 1'b0; btn_cancel = 1'b0;
    sw_in = 8'h00; preset_in = 24'h0;
    cyc(); cyc();
    chk_reset("rst");
    rst = 1'b0;
    cyc();

    // Entry and capture, target 1
    preset_in = 24'h210115;
    pulse_req(3'b010);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_target", 32'(target), 1);
    chk("t1_preload", 32'(buf_out), 32'h210115);
    press(1, 0, 0, 8'h22);
    chk("t1_step1", 32'(step), 1);
    press(1, 0, 0, 8'h04);
    chk("t1_step2", 32'(step), 2);
    push_commit(3'b010, 24'h190422);
    press(1, 0, 0, 8'h19);
    chk("t1_busy_commit", 32'(busy), 1);
    req = 3'b001;
    cyc();
    req = 3'b000;
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_req_ignored", 32'(target), 1);
    chk("t1_buf_hold", 32'(buf_out), 32'h190422);
    cyc();
    chk("t1_still_idle", 32'(busy), 0);

    // Back step, target 0
    preset_in = 24'h001530;
    pulse_req(3'b001);
    chk("t2_target", 32'(target), 0);
    press(1, 0, 0, 8'h08);
    chk("t2_step_a", 32'(step), 1);
    press(0, 1, 0, 8'h45);
    chk("t2_step_b", 32'(step), 0);
    press(1, 0, 0, 8'h09);
    chk("t2_step_c", 32'(step), 1);
    push_commit(3'b001, 24'h004509);
    press(1, 0, 0, 8'h45);
    cyc(); cyc();

    // Arbitration, cancel beats next
    pulse_req(3'b110);
    chk("t3_arb", 32'(target), 1);
    push_abort();
    press(1, 0, 1, 8'h33);
    chk("t3_busy", 32'(busy), 0);
    cyc(); cyc();

    // Back at step 0, req ignored in EDIT
    pulse_req(3'b001);
    press(0, 1, 0, 8'h01);
    chk("t4_back0", 32'(step), 0);
    pulse_req(3'b010);
    chk("t4_req_edit_tgt", 32'(target), 0);
    chk("t4_req_edit_busy", 32'(busy), 1);
    push_abort();
    press(0, 0, 1, 8'h01);
    cyc(); cyc();

    // Timeout after three idle ticks
    preset_in = 24'h0;
    pulse_req(3'b100);
    pulse_tick(0);
    pulse_tick(0);
    chk("t5_busy_pre", 32'(busy), 1);
    push_abort();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("t5_busy_post", 32'(busy), 0);
    cyc(); cyc();

    // Button with tick clears the timer
    pulse_req(3'b100);
    pulse_tick(0);
    pulse_tick(1);
    chk("t6_step", 32'(step), 1);
    pulse_tick(0);
    pulse_tick(0);
    chk("t6_no_abort", 32'(busy), 1);
    push_abort();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("t6_busy_post", 32'(busy), 0);
    cyc(); cyc();

    // Reset mid-EDIT
    preset_in = 24'h001530;
    pulse_req(3'b001);
    press(1, 0, 0, 8'h77);
    chk("t7_step1", 32'(step), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_reset("t7_rst");
    cyc();
    preset_in = 24'h002244;
    pulse_req(3'b001);
    chk("t7_step0", 32'(step), 0);
    chk("t7_preload", 32'(buf_out), 32'h002244);
    press(1, 0, 0, 8'h11);
    push_commit(3'b001, 24'h009911);
    press(1, 0, 0, 8'h99);
    cyc(); cyc(); cyc();

    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/field_entry_ctrl.md
Name: field_entry_ctrl

Overview:
Parametrised multi-target, multi-field value-entry controller for the clock test boards. It generalises the fixed time/date/alarm entry sequencer into N targets, each with its own field count. It adds preload of current values, a back step, explicit cancel and an inactivity timeout. It sits between debounced buttons/switches and the clockwork, calendar and alarm overwrite inputs, and produces a per-target one-cycle commit pulse.

Parameters:
NUM_TARGETS, 3, number of entry targets (e.g. 0=time, 1=date, 2=alarm); 1..8
NUM_FIELDS, 3, maximum fields per target; 1..8
FIELD_W, 8, bits per field
TARGET_STEPS, {3'd2,3'd3,3'd2}, packed 3-bit field count per target (target 0 in LSBs); each 1..NUM_FIELDS
TIMEOUT_TICKS, 10, tick pulses of inactivity before abort; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NUM_TARGETS  start-entry pulses (debounced, one cycle)
btn_next  in  1  accept field / advance (pulse)
btn_back  in  1  return to previous field (pulse)
btn_cancel  in  1  abort entry (pulse)
tick  in  1  1 Hz enable pulse, one clk wide
sw_in  in  FIELD_W  live field value from switches
preset_in  in  NUM_FIELDS*FIELD_W  current value of the target, field 0 in LSBs
busy  out  1  high in EDIT or COMMIT
target  out  3  active/last target index
step  out  3  current field index
buf_out  out  NUM_FIELDS*FIELD_W  entry buffer, field 0 in LSBs
commit  out  NUM_TARGETS  one-cycle overwrite pulse for target
aborted  out  1  one-cycle pulse after cancel or timeout

Behaviour:
- Reset (sync, all state): state=IDLE, busy=0, target=0, step=0, buf_out=0, commit=0, aborted=0, timer=0.
- States: IDLE, EDIT, COMMIT.
- IDLE: if any req bit is set, select the lowest set index. Then target<=index, buf<=preset_in, step<=0, timer<=0, state<=EDIT. req is ignored outside IDLE.
- EDIT, live capture: every cycle, field[step]<=sw_in, using the pre-edge step. Fields at or beyond the target's step count keep their preset value.
- EDIT button priority in one cycle: cancel > next > back.
  - cancel: state<=IDLE; aborted=1 on the following cycle. buf keeps its contents but no commit is issued.
  - next with step==TARGET_STEPS[target]-1: state<=COMMIT.
  - next otherwise: step<=step+1.
  - back: step<=step-1 if step>0, else no change. Back at field 0 still counts as activity.
- Timer: cleared on next, back or entry; incremented on tick otherwise. If TIMEOUT_TICKS>0, a tick arriving with timer==TIMEOUT_TICKS-1 and no button that cycle causes abort, behaving exactly like cancel. A button and a tick in the same cycle: the button wins and the timer clears.
- COMMIT: lasts exactly one cycle. commit[target]=1 and all other bits are 0; buf_out holds the final values, including the sw_in captured in the cycle next was pressed. state<=IDLE.
- Latency: final next at edge N gives commit high in cycle N+1. A req in the commit cycle is ignored; a req in cycle N+2 is honoured.
- buf_out, target and step hold their values in IDLE until the next entry.
- step saturates within 0..TARGET_STEPS[target]-1. It never wraps.
- Reset mid-EDIT: returns to IDLE and produces no commit and no aborted pulse.

Decomposition:
- Package field_entry_pkg:
  - state encoding localparams ST_IDLE, ST_EDIT, ST_COMMIT
  - MAX_TARGETS=8, MAX_FIELDS=8
  - function steps_of(target) to extract the 3-bit count from TARGET_STEPS
- Sub-module entry_timeout: timer counter with clear, tick and expire outputs, parametrised by TIMEOUT_TICKS. When TIMEOUT_TICKS=0 the expire output is tied low.
- Priority encoder and field write-enable decode stay inline.

Test Plan:
- Entry and capture. Defaults, preset_in=0x210115. Pulse req=3'b010, then sw_in=0x22 and next, sw_in=0x04 and next, sw_in=0x19 and next.
  -> busy=1, steps 0→1→2; in the cycle after the third next, commit=3'b010 for one cycle and buf_out=0x190422; busy=0 in the following cycle.
- Back step. Target 0, preset 0x1530. Sequence: sw=0x08 next, sw=0x45 back, sw=0x09 next, sw=0x45 next.
  -> step goes 0,1,0,1; commit=3'b001 with buf_out=0x4509.
- Cancel and precedence.
  - In EDIT, assert cancel and next together -> state IDLE, aborted pulse one cycle later, commit stays 0.
  - back at step 0 -> step stays 0.
- Timeout. TIMEOUT_TICKS=3, target 2 in EDIT, no buttons, three tick pulses -> aborted one cycle after the third tick.
  - Same run with next in the cycle of the second tick -> no abort until three further ticks.
- Arbitration and ignore. req=3'b110 in IDLE -> target=1. req=3'b001 during EDIT and during COMMIT -> ignored, no restart.
- Reset mid-EDIT at step 1 -> all outputs at reset values next cycle, no commit or aborted pulse; a new req then starts at step 0 with preset reloaded.
